// File: rtl/counting_pkg.sv
// Shared types and constants for the counting scheduler: controller and
// detector state encodings, symbol values and the stall-timeout limit.
package counting_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        REPORT = 2'd2
    } ctrl_state_e;

    typedef enum logic [1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2,
        D3 = 2'd3
    } det_state_e;

    localparam logic [1:0] SYM_1 = 2'd1;
    localparam logic [1:0] SYM_2 = 2'd2;
    localparam logic [1:0] SYM_3 = 2'd3;

    // Consecutive transfer-free STREAM cycles that end a packet early
    localparam logic [7:0] IDLE_LIMIT = 8'd255;

endpackage

// File: rtl/seq_detect_core.sv
// 1-2-3 pattern detector: symbol 0 is a bubble, hit pulses on the D2->D3 step.
module seq_detect_core
    import counting_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    input  logic [1:0] sym,
    output logic       hit
);

    det_state_e state_q, state_d;

    // Detector state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= D0;
        end else begin
            state_q <= state_d;
        end
    end

    // Detector transition and hit decode
    always_comb begin
        state_d = state_q;
        hit     = 1'b0;
        if (clear) begin
            state_d = D0;
        end else if (en && (sym != 2'd0)) begin
            case (state_q)
                D0: state_d = (sym == SYM_1) ? D1 : D0;
                D1: state_d = (sym == SYM_1) ? D1 : ((sym == SYM_2) ? D2 : D0);
                D2: begin
                    state_d = (sym == SYM_1) ? D1 : ((sym == SYM_2) ? D2 : D3);
                    hit     = (sym == SYM_3);
                end
                D3: state_d = (sym == SYM_1) ? D1 : ((sym == SYM_2) ? D0 : D3);
                default: state_d = D0;
            endcase
        end else begin
            state_d = state_q;
        end
    end

endmodule

// File: rtl/counting_sched.sv
// Round-robin shared 1-2-3 match counter. Optional stall timeout with
// res_timeout output is enabled by defining COUNTING_SCHED_TIMEOUT_EN.
module counting_sched
    import counting_pkg::*;
#(
    parameter int  NREQ  = 4,
    parameter int  CNT_W = 8,
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   sym_valid,
    input  logic [2*NREQ-1:0] sym,
    input  logic [NREQ-1:0]   sym_last,
    output logic [NREQ-1:0]   sym_ready,
    output logic [NREQ-1:0]   grant,
    output logic              res_valid,
    output logic [ID_W-1:0]   res_id,
    output logic [CNT_W-1:0]  res_count
`ifdef COUNTING_SCHED_TIMEOUT_EN
    ,
    output logic              res_timeout
`endif
);

    ctrl_state_e      state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]  gidx_q, gidx_d, ptr_q, ptr_d, res_id_q, res_id_d;
    logic [ID_W-1:0]  rr_idx_s, cand_s;
    logic             rr_found_s;
    logic [CNT_W-1:0] count_q, count_d, cnt_next_s, res_count_q, res_count_d;
    logic             res_valid_q, res_valid_d;
    logic             xfer_s, last_s, hit_s, det_clear_s, timeout_s;
    logic [1:0]       sym_sel_s;

    // Round-robin search for the first requester at or after the pointer
    always_comb begin
        rr_found_s = 1'b0;
        rr_idx_s   = {ID_W{1'b0}};
        cand_s     = {ID_W{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            cand_s = ID_W'((int'(ptr_q) + k) % NREQ);
            if (!rr_found_s && req[cand_s]) begin
                rr_found_s = 1'b1;
                rr_idx_s   = cand_s;
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    assign xfer_s     = (state_q == STREAM) && sym_valid[gidx_q];
    assign last_s     = sym_last[gidx_q];
    assign sym_sel_s  = sym[{gidx_q, 1'b0} +: 2];
    assign cnt_next_s = (hit_s && (count_q != {CNT_W{1'b1}})) ? (count_q + CNT_W'(1'b1)) : count_q;

    seq_detect_core u_det (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (det_clear_s),
        .en    (xfer_s),
        .sym   (sym_sel_s),
        .hit   (hit_s)
    );

    // Controller next-state and result capture
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        det_clear_s = 1'b0;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_count_d = res_count_q;
        case (state_q)
            IDLE: begin
                if (rr_found_s) begin
                    state_d     = STREAM;
                    grant_d     = NREQ'(1'b1) << rr_idx_s;
                    gidx_d      = rr_idx_s;
                    ptr_d       = (int'(rr_idx_s) == NREQ - 1) ? {ID_W{1'b0}} : (rr_idx_s + ID_W'(1'b1));
                    count_d     = {CNT_W{1'b0}};
                    det_clear_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (xfer_s) begin
                    count_d = cnt_next_s;
                    if (last_s) begin
                        state_d     = REPORT;
                        res_valid_d = 1'b1;
                        res_id_d    = gidx_q;
                        res_count_d = cnt_next_s;
                    end else begin
                        state_d = STREAM;
                    end
                end else if (timeout_s) begin
                    state_d     = REPORT;
                    res_valid_d = 1'b1;
                    res_id_d    = gidx_q;
                    res_count_d = count_q;
                end else begin
                    state_d = STREAM;
                end
            end
            REPORT: begin
                state_d = IDLE;
                grant_d = {NREQ{1'b0}};
            end
            default: begin
                state_d = IDLE;
                grant_d = {NREQ{1'b0}};
            end
        endcase
    end

    // Controller and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= {NREQ{1'b0}};
            gidx_q      <= {ID_W{1'b0}};
            ptr_q       <= {ID_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            res_valid_q <= 1'b0;
            res_id_q    <= {ID_W{1'b0}};
            res_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_count_q <= res_count_d;
        end
    end

`ifdef COUNTING_SCHED_TIMEOUT_EN
    logic [7:0] idle_q, idle_d;
    logic       res_timeout_q, res_timeout_d;

    assign timeout_s = (state_q == STREAM) && !xfer_s && (idle_q == (IDLE_LIMIT - 8'd1));

    // Stall counter and sticky timeout flag
    always_comb begin
        idle_d        = idle_q;
        res_timeout_d = res_timeout_q;
        if ((state_q == STREAM) && !xfer_s) begin
            idle_d = idle_q + 8'd1;
        end else begin
            idle_d = 8'd0;
        end
        if (timeout_s) begin
            res_timeout_d = 1'b1;
        end else if (xfer_s && last_s) begin
            res_timeout_d = 1'b0;
        end else begin
            res_timeout_d = res_timeout_q;
        end
    end

    // Timeout registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q        <= 8'd0;
            res_timeout_q <= 1'b0;
        end else begin
            idle_q        <= idle_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign res_timeout = res_timeout_q;
`else
    assign timeout_s = 1'b0;
`endif

    assign sym_ready = (state_q == STREAM) ? grant_q : {NREQ{1'b0}};
    assign grant     = grant_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_count = res_count_q;

endmodule

// File: doc/counting_sched.md
COUNTING_SCHED -- requirements
Module: counting_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesters sharing the detector.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the match-counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port req, input, NREQ bits: per-requester stream request.
REQ-006 SHALL have port sym_valid, input, NREQ bits: per-requester symbol valid.
REQ-007 SHALL have port sym, input, 2*NREQ bits: per-requester 2-bit symbol, requester i at bits [2i+1:2i].
REQ-008 SHALL have port sym_last, input, NREQ bits: marks the last symbol of a packet.
REQ-009 SHALL have port sym_ready, output, NREQ bits: per-requester symbol accept.
REQ-010 SHALL have port grant, output, NREQ bits: one-hot owner of the detector.
REQ-011 SHALL have port res_valid, output, 1 bit: one-cycle result strobe.
REQ-012 SHALL have port res_id, output, $clog2(NREQ) bits: index of the requester reported.
REQ-013 SHALL have port res_count, output, CNT_W bits: number of 1-2-3 matches in the packet.

Function
REQ-014 SHALL use a controller FSM with states IDLE, STREAM and REPORT.
REQ-015 SHALL, in IDLE with req nonzero, grant round-robin starting at the pointer, load grant, clear the detector and count, and go to STREAM on the next edge.
REQ-016 SHALL set the round-robin pointer to (granted index + 1) mod NREQ at each grant; with a single requester it SHALL re-grant the same index.
REQ-017 SHALL drive sym_ready = grant only in STREAM and 0 elsewhere; a transfer is sym_valid[g] & sym_ready[g].
REQ-018 SHALL run the detector on each transfer, with states D0..D3 and symbol 0 holding state in every state.
REQ-019 SHALL apply detector transitions from D0: 1->D1, 2 or 3->D0.
REQ-020 SHALL apply detector transitions from D1: 1->D1, 2->D2, 3->D0.
REQ-021 SHALL apply detector transitions from D2: 1->D1, 2->D2, 3->D3.
REQ-022 SHALL apply detector transitions from D3: 1->D1, 2->D0, 3->D3.
REQ-023 SHALL increment count only on a D2->D3 transition and saturate at all-ones; staying in D3 SHALL NOT count.
REQ-024 SHALL, on a transfer with sym_last, go to REPORT; the count SHALL include that symbol.
REQ-025 SHALL, in REPORT, assert res_valid for exactly 1 cycle with res_id and res_count, clear grant, and return to IDLE.
REQ-026 SHALL hold res_id and res_count stable until the next REPORT.
REQ-027 SHALL give minimum packet latency from the req-sampled edge = 1 (grant) + N transfers + 1 (res_valid).
REQ-028 SHALL, if req[g] deasserts mid-STREAM, keep the grant; only sym_last ends a packet.
REQ-029 SHALL ignore sym_valid and sym of non-granted requesters.

Reset
REQ-030 SHALL, while rst_n is low, asynchronously force: state IDLE, detector D0, count 0, pointer 0, grant 0, sym_ready 0, res_valid 0, res_id 0, res_count 0.
REQ-031 SHALL, on reset mid-STREAM, discard the packet and produce no result.

Configuration
REQ-032 SHALL, with COUNTING_SCHED_TIMEOUT_EN defined, add output res_timeout and an 8-bit idle counter; 255 consecutive STREAM cycles without a transfer SHALL force REPORT with res_timeout=1 and the partial count.
REQ-033 SHALL, without COUNTING_SCHED_TIMEOUT_EN, omit the res_timeout port and the idle counter, and STREAM SHALL wait indefinitely.

Structure
REQ-034 SHALL put the controller state enum, the detector state enum D0..D3 and the symbol constants 1/2/3 in shared package counting_pkg.
REQ-035 SHALL implement the detector as sub-module seq_detect_core (clk, rst_n, clear, en, sym -> hit).

Verification
REQ-036 SHALL verify that req=0001 with symbols 1,2,3 (last on the 3) gives grant 0001 one cycle after req, then res_valid=1, res_id=0, res_count=1.
REQ-037 SHALL verify that symbols 1,2,3,3,1,2,3,2 give count 2 (D3 self-loop not counted).
REQ-038 SHALL verify that req=1111 held with one-symbol packets gives grant order 0001, 0010, 0100, 1000, 0001.
REQ-039 SHALL verify that with CNT_W=2, four 1,2,3 repeats give count 3 (saturation).
REQ-040 SHALL verify that rst_n low after 2 transfers gives grant=0, no res_valid, and the next packet is granted from pointer 0.
REQ-041 SHALL verify that with COUNTING_SCHED_TIMEOUT_EN, 1,2 then 255 stall cycles give res_valid, res_timeout=1 and res_count=0.
